// File: rtl/lcd_cell_writer.sv
// rtl/lcd_cell_writer.sv - fills one grid cell on an 8080-style 8-bit LCD panel.
// Also emits the panel init sequence.
module lcd_cell_writer #(
    parameter int GRID_W    = 4,
    parameter int CELL_PX   = 20,
    parameter int WR_LOW    = 1,
    parameter int INIT_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [GRID_W-1:0] x,
    input  logic [GRID_W-1:0] y,
    input  logic [15:0]       color,
    output logic              busy,
    output logic              done,
    output logic              csx_n,
    output logic              wr_n,
    output logic              dcx,
    output logic [7:0]        d
);

    localparam logic [1:0]  OP_DRAW   = 2'b00;
    localparam logic [1:0]  OP_CLEAR  = 2'b01;
    localparam logic [1:0]  OP_INIT   = 2'b10;
    localparam logic [1:0]  OP_NOP    = 2'b11;
    localparam logic [15:0] PH_LAST   = 16'(WR_LOW - 1);
    localparam logic [15:0] WAIT_LAST = 16'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
    localparam logic [15:0] PIX_LAST  = 16'(CELL_PX * CELL_PX - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_WAIT, S_PIXEL, S_DONE} state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [GRID_W-1:0]  x_q, y_q;
    logic [15:0]        color_q;
    logic [3:0]         step_q;
    logic [15:0]        phase_q, wait_q, pix_q;
    logic               hi_q;
    logic               busy_q, done_q, csx_q, wr_q, dcx_q;
    logic [7:0]         d_q;

    logic [15:0] x0, x1, y0, y1;
    logic [3:0]  nstep;
    logic [7:0]  nhdr_d, pix_hi, pix_lo;
    logic        nhdr_cmd, hdr_last, wait_after;

    assign x0 = 16'(x_q) * 16'(CELL_PX);
    assign y0 = 16'(y_q) * 16'(CELL_PX);
    assign x1 = x0 + 16'(CELL_PX - 1);
    assign y1 = y0 + 16'(CELL_PX - 1);

    // Header byte that follows the one currently on the bus.
    always_comb begin
        nstep      = step_q + 4'd1;
        nhdr_d     = 8'h00;
        nhdr_cmd   = 1'b0;
        pix_hi     = (op_q == OP_CLEAR) ? 8'h00 : color_q[15:8];
        pix_lo     = (op_q == OP_CLEAR) ? 8'h00 : color_q[7:0];
        hdr_last   = (op_q == OP_INIT) ? (step_q == 4'd4) : (step_q == 4'd10);
        wait_after = (op_q == OP_INIT) && (step_q <= 4'd1);
        if (op_q == OP_INIT) begin
            case (nstep)
                4'd1:    begin nhdr_d = 8'h11; nhdr_cmd = 1'b1; end
                4'd2:    begin nhdr_d = 8'h3A; nhdr_cmd = 1'b1; end
                4'd3:    nhdr_d = 8'h55;
                4'd4:    begin nhdr_d = 8'h29; nhdr_cmd = 1'b1; end
                default: nhdr_d = 8'h00;
            endcase
        end else begin
            case (nstep)
                4'd1:    nhdr_d = x0[15:8];
                4'd2:    nhdr_d = x0[7:0];
                4'd3:    nhdr_d = x1[15:8];
                4'd4:    nhdr_d = x1[7:0];
                4'd5:    begin nhdr_d = 8'h2B; nhdr_cmd = 1'b1; end
                4'd6:    nhdr_d = y0[15:8];
                4'd7:    nhdr_d = y0[7:0];
                4'd8:    nhdr_d = y1[15:8];
                4'd9:    nhdr_d = y1[7:0];
                4'd10:   begin nhdr_d = 8'h2C; nhdr_cmd = 1'b1; end
                default: nhdr_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_DRAW;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= 16'h0000;
            step_q  <= 4'd0;
            phase_q <= 16'd0;
            wait_q  <= 16'd0;
            pix_q   <= 16'd0;
            hi_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            csx_q   <= 1'b1;
            wr_q    <= 1'b1;
            dcx_q   <= 1'b1;
            d_q     <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        x_q     <= x;
                        y_q     <= y;
                        color_q <= color;
                        step_q  <= 4'd0;
                        phase_q <= 16'd0;
                        if (op == OP_NOP) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CMD;
                            busy_q  <= 1'b1;
                            csx_q   <= 1'b0;
                            wr_q    <= 1'b0;
                            dcx_q   <= 1'b0;
                            d_q     <= (op == OP_INIT) ? 8'h01 : 8'h2A;
                        end
                    end
                end
                S_CMD, S_DATA, S_PIXEL: begin
                    if (phase_q != PH_LAST) begin
                        phase_q <= phase_q + 16'd1;
                    end else begin
                        phase_q <= 16'd0;
                        if (!wr_q) begin
                            wr_q <= 1'b1;
                        end else if (state_q == S_PIXEL) begin
                            if (hi_q) begin
                                hi_q <= 1'b0;
                                d_q  <= pix_lo;
                                wr_q <= 1'b0;
                            end else if (pix_q == PIX_LAST) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                csx_q   <= 1'b1;
                                dcx_q   <= 1'b1;
                                d_q     <= 8'h00;
                            end else begin
                                pix_q <= pix_q + 16'd1;
                                hi_q  <= 1'b1;
                                d_q   <= pix_hi;
                                wr_q  <= 1'b0;
                            end
                        end else if (hdr_last) begin
                            if (op_q == OP_INIT) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                csx_q   <= 1'b1;
                                dcx_q   <= 1'b1;
                                d_q     <= 8'h00;
                            end else begin
                                state_q <= S_PIXEL;
                                pix_q   <= 16'd0;
                                hi_q    <= 1'b1;
                                d_q     <= pix_hi;
                                dcx_q   <= 1'b1;
                                wr_q    <= 1'b0;
                            end
                        end else if (wait_after && (INIT_WAIT > 0)) begin
                            state_q <= S_WAIT;
                            wait_q  <= 16'd0;
                        end else begin
                            state_q <= nhdr_cmd ? S_CMD : S_DATA;
                            step_q  <= nstep;
                            d_q     <= nhdr_d;
                            dcx_q   <= ~nhdr_cmd;
                            wr_q    <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // csx_n stays low and wr_n high while the panel settles.
                    if (wait_q == WAIT_LAST) begin
                        wait_q  <= 16'd0;
                        state_q <= nhdr_cmd ? S_CMD : S_DATA;
                        step_q  <= nstep;
                        d_q     <= nhdr_d;
                        dcx_q   <= ~nhdr_cmd;
                        wr_q    <= 1'b0;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign csx_n = csx_q;
    assign wr_n  = wr_q;
    assign dcx   = dcx_q;
    assign d     = d_q;

endmodule

// File: tb/tb_lcd_cell_writer.sv
// tb/tb_lcd_cell_writer.sv - directed bench for lcd_cell_writer.
// Three instances cover default, CELL_PX=1 and WR_LOW=2 configurations.
module tb_lcd_cell_writer;

    localparam logic [1:0] OP_DRAW = 2'b00, OP_CLEAR = 2'b01, OP_INIT = 2'b10, OP_NOP = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  x = 4'd0, y = 4'd0;
    logic [15:0] color = 16'h0000;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [1:0]  op_a = 2'b00, op_b = 2'b00, op_c = 2'b00;
    logic        busy_a, done_a, csx_a, wr_a, dcx_a;
    logic        busy_b, done_b, csx_b, wr_b, dcx_b;
    logic        busy_c, done_c, csx_c, wr_c, dcx_c;
    logic [7:0]  d_a, d_b, d_c;

    always #5 clk = ~clk;

    lcd_cell_writer u_a (
        .clk(clk), .rst(rst), .start(start_a), .op(op_a), .x(x), .y(y), .color(color),
        .busy(busy_a), .done(done_a), .csx_n(csx_a), .wr_n(wr_a), .dcx(dcx_a), .d(d_a));

    lcd_cell_writer #(.CELL_PX(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .op(op_b), .x(x), .y(y), .color(color),
        .busy(busy_b), .done(done_b), .csx_n(csx_b), .wr_n(wr_b), .dcx(dcx_b), .d(d_b));

    lcd_cell_writer #(.WR_LOW(2), .INIT_WAIT(16)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .op(op_c), .x(x), .y(y), .color(color),
        .busy(busy_c), .done(done_c), .csx_n(csx_c), .wr_n(wr_c), .dcx(dcx_c), .d(d_c));

    int checks = 0, errors = 0;
    int cyc = 0;
    int nd_a = 0, nd_b = 0, nd_c = 0;
    int lrun_c = 0, bad_csx_c = 0;
    logic pw_a = 1'b1, pw_b = 1'b1, pw_c = 1'b1;
    logic [8:0] q_a[$], q_b[$], q_c[$], exp_q[$];
    int t_c[$], lr_c[$];

    // Byte capture: a byte is recorded with its dcx when wr_n falls.
    always @(negedge clk) begin
        cyc++;
        if (!wr_a && pw_a) q_a.push_back({dcx_a, d_a});
        if (!wr_b && pw_b) q_b.push_back({dcx_b, d_b});
        if (!wr_c && pw_c) begin
            q_c.push_back({dcx_c, d_c});
            t_c.push_back(cyc);
        end
        if (!wr_c) lrun_c++;
        else if (!pw_c) begin
            lr_c.push_back(lrun_c);
            lrun_c = 0;
        end
        if (busy_c && csx_c) bad_csx_c++;
        if (done_a) nd_a++;
        if (done_b) nd_b++;
        if (done_c) nd_c++;
        pw_a = wr_a;
        pw_b = wr_b;
        pw_c = wr_c;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int which, input logic [1:0] o, output int acc);
        @(negedge clk);
        #1;
        case (which)
            0: begin op_a = o; start_a = 1'b1; end
            1: begin op_b = o; start_b = 1'b1; end
            default: begin op_c = o; start_c = 1'b1; end
        endcase
        acc = cyc;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int which, input int acc, output int lat);
        logic dn;
        lat = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            dn = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
            if (dn) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    task automatic mk_cell(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] y0,
                           input logic [15:0] y1, input int npix, input logic [15:0] pix);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < npix; i++) begin
            exp_q.push_back({1'b1, pix[15:8]});
            exp_q.push_back({1'b1, pix[7:0]});
        end
    endtask

    task automatic cmp_q(input string tag, input logic [8:0] got[$]);
        int bad;
        bad = -1;
        chk({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i] && bad < 0) bad = i;
        chk({tag, " first bad index"}, bad, -1);
    endtask

    initial begin
        int acc, lat, n0, nb, badlr;

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy_a, 0);
        chk("reset done", done_a, 0);
        chk("reset csx_n", csx_a, 1);
        chk("reset wr_n", wr_a, 1);
        chk("reset dcx", dcx_a, 1);
        chk("reset d", d_a, 0);
        rst = 1'b0;

        // DRAW x=3 y=2: x0=60 x1=79 y0=40 y1=59
        x = 4'd3; y = 4'd2; color = 16'hF800;
        q_a.delete(); n0 = nd_a;
        go(0, OP_DRAW, acc);
        chk("draw busy", busy_a, 1);
        chk("draw first wr_n", wr_a, 0);
        chk("draw first csx_n", csx_a, 0);
        chk("draw first dcx", dcx_a, 0);
        wait_done(0, acc, lat);
        chk("draw latency", lat, 1623);
        chk("draw busy at done", busy_a, 0);
        chk("draw csx_n at done", csx_a, 1);
        mk_cell(16'h003C, 16'h004F, 16'h0028, 16'h003B, 400, 16'hF800);
        cmp_q("draw bytes", q_a);

        // NOP started in the cycle right after done
        nb = q_a.size();
        go(0, OP_NOP, acc);
        wait_done(0, acc, lat);
        chk("b2b nop latency", lat, 1);
        chk("b2b nop bytes", q_a.size(), nb);
        chk("b2b done pulses", nd_a - n0, 2);

        // CLEAR with CELL_PX=1 ignores a nonzero color
        x = 4'd0; y = 4'd0; color = 16'hFFFF;
        q_b.delete();
        go(1, OP_CLEAR, acc);
        wait_done(1, acc, lat);
        chk("clear latency", lat, 27);
        mk_cell(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000);
        cmp_q("clear bytes", q_b);

        // INIT with WR_LOW=2, INIT_WAIT=16
        q_c.delete(); t_c.delete(); lr_c.delete();
        go(2, OP_INIT, acc);
        wait_done(2, acc, lat);
        chk("init latency", lat, 53);
        exp_q.delete();
        exp_q.push_back(9'h001); exp_q.push_back(9'h011); exp_q.push_back(9'h03A);
        exp_q.push_back(9'h155); exp_q.push_back(9'h029);
        cmp_q("init bytes", q_c);
        chk("init start gap 0-1", (t_c.size() >= 2) ? t_c[1] - t_c[0] : -1, 20);
        chk("init start gap 1-2", (t_c.size() >= 3) ? t_c[2] - t_c[1] : -1, 20);
        chk("init start gap 2-3", (t_c.size() >= 4) ? t_c[3] - t_c[2] : -1, 4);
        chk("init start gap 3-4", (t_c.size() >= 5) ? t_c[4] - t_c[3] : -1, 4);
        badlr = 0;
        foreach (lr_c[i]) if (lr_c[i] != 2) badlr++;
        chk("init low phases", lr_c.size(), 5);
        chk("init low phase length", badlr, 0);
        chk("init csx_n high while busy", bad_csx_c, 0);

        // Start with op=INIT injected mid-DRAW; x0=20 x1=39 y0=80 y1=99
        x = 4'd1; y = 4'd4; color = 16'h07E0;
        q_a.delete(); n0 = nd_a;
        go(0, OP_DRAW, acc);
        repeat (30) @(negedge clk);
        #1;
        op_a = OP_INIT; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_done(0, acc, lat);
        chk("inject latency", lat, 1623);
        mk_cell(16'h0014, 16'h0027, 16'h0050, 16'h0063, 400, 16'h07E0);
        cmp_q("inject bytes", q_a);
        repeat (4) @(negedge clk);
        chk("inject done pulses", nd_a - n0, 1);

        // Reset during the PIXEL phase, then a NOP
        n0 = nd_a;
        go(0, OP_DRAW, acc);
        repeat (100) @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort csx_n", csx_a, 1);
        chk("abort wr_n", wr_a, 1);
        chk("abort busy", busy_a, 0);
        chk("abort done", done_a, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort no done", nd_a - n0, 0);
        go(0, OP_NOP, acc);
        wait_done(0, acc, lat);
        chk("post-abort nop latency", lat, 1);
        chk("post-abort done pulses", nd_a - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
